sequence_player: RTL and testbench

// - Sequence side of the Simon game: grows a pseudo-random colour sequence one entry per round,

---
 rtl/sequence_player_if.sv | 47 ++++
 rtl/sequence_player.sv | 206 ++++++++++++++++++++
 tb/tb_sequence_player.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sequence_player_if.sv
// sequence_player_if
// Groups the handshake between the Simon sequence player and its
// neighbours (game FSM / UI on one side, colour comparator on the other).
//
// Signals
//   start       game FSM -> player : 1-cycle pulse, begin a new game
//   press       UI -> player       : 1-cycle pulse, player pressed a button
//   cmp_result  comparator -> player : 01 match, 10 mismatch, else invalid
//   expected    player -> comparator : colour the press must match
//   cmp_enable  player -> comparator : 1 cycle per accepted press
//   led_on      player -> LEDs     : playback LED lit
//   led_colour  player -> LEDs     : colour being played back
//   level       player -> UI       : current sequence length
//   round_done  player -> UI       : 1-cycle pulse, round fully matched
//   game_won    player -> UI       : high while in WIN
//   game_over   player -> UI       : high while in FAIL
//
// Modports: slave = the sequence player, master = its environment.
interface sequence_player_if #(
  parameter int MAX_LEN = 16
) ();
  localparam int LVL_W = $clog2(MAX_LEN + 1);

  logic             start;
  logic             press;
  logic [1:0]       cmp_result;
  logic [1:0]       expected;
  logic             cmp_enable;
  logic             led_on;
  logic [1:0]       led_colour;
  logic [LVL_W-1:0] level;
  logic             round_done;
  logic             game_won;
  logic             game_over;

  modport slave (
    input  start, press, cmp_result,
    output expected, cmp_enable, led_on, led_colour, level,
           round_done, game_won, game_over
  );

  modport master (
    output start, press, cmp_result,
    input  expected, cmp_enable, led_on, led_colour, level,
           round_done, game_won, game_over
  );
endinterface

// File: rtl/sequence_player.sv
// sequence_player
// Sequence side of the Simon game. Each round appends one pseudo-random
// colour to the stored sequence, plays the whole sequence on the LEDs, then
// presents the expected colour for every player press to the comparator and
// acts on the comparator's registered verdict (advance / next round / win /
// fail).
//
// Ports
//   clk     : system clock, all logic on posedge
//   resetn  : synchronous active-low reset
//   bus     : sequence_player_if.slave (start, press, cmp_result in;
//             expected, cmp_enable, led_on, led_colour, level,
//             round_done, game_won, game_over out)
//
// Configuration macro
//   SIMON_TIMEOUT_EN : when defined, WAIT_PRESS fails the game after
//                      TIMEOUT_TICKS idle cycles; when undefined the player
//                      may wait forever and TIMEOUT_TICKS is only range-checked.
module sequence_player #(
  parameter int         MAX_LEN       = 16,
  parameter int         TICKS_ON      = 25_000_000,
  parameter int         TICKS_OFF     = 12_500_000,
  parameter logic [7:0] SEED          = 8'hA5,
  parameter int         TIMEOUT_TICKS = 250_000_000
) (
  input logic              clk,
  input logic              resetn,
  sequence_player_if.slave bus
);

  localparam int LVL_W    = $clog2(MAX_LEN + 1);
  localparam int IDX_W    = $clog2(MAX_LEN);
  localparam int TICK_MAX = (TICKS_ON > TICKS_OFF) ? TICKS_ON : TICKS_OFF;
  localparam int CNT_W    = $clog2(TICK_MAX + 1);

  // Elaboration-time parameter sanity (an all-zero LFSR would lock up)
  if (MAX_LEN < 2 || MAX_LEN > 256) begin : g_bad_max_len
    $error("sequence_player: MAX_LEN must be 2..256");
  end
  if (SEED == 8'h00) begin : g_bad_seed
    $error("sequence_player: SEED must be nonzero");
  end
  if (TICKS_ON < 1 || TICKS_OFF < 1 || TIMEOUT_TICKS < 1) begin : g_bad_ticks
    $error("sequence_player: tick parameters must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ADD        = 3'd1,
    S_SHOW_ON    = 3'd2,
    S_SHOW_OFF   = 3'd3,
    S_WAIT_PRESS = 3'd4,
    S_CHECK      = 3'd5,
    S_WIN        = 3'd6,
    S_FAIL       = 3'd7
  } state_t;

  state_t           state_r;
  logic [7:0]       lfsr_r;
  logic [1:0]       seq_r [MAX_LEN];
  logic [LVL_W-1:0] level_r;
  logic [IDX_W-1:0] idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic             led_on_r;
  logic             round_done_r;
  logic             game_won_r;
  logic             game_over_r;
  logic [LVL_W-1:0] idx_inc_s;
  logic             timeout_hit_s;

  // idx+1 widened to level width so "more entries left" is a plain compare
  assign idx_inc_s = LVL_W'(idx_r) + LVL_W'(1);

`ifdef SIMON_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  logic [TO_W-1:0] tout_r;

  // Idle counter: runs only while waiting for a press, cleared otherwise
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tout_r <= TO_W'(0);
    end else if (state_r != S_WAIT_PRESS || bus.press) begin
      tout_r <= TO_W'(0);
    end else begin
      tout_r <= tout_r + TO_W'(1);
    end
  end

  assign timeout_hit_s = (state_r == S_WAIT_PRESS) && (tout_r == TO_W'(TIMEOUT_TICKS - 1));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Free-running Fibonacci LFSR (x^8+x^6+x^5+x^4+1) supplying new colours
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr_r <= SEED;
    end else begin
      lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    end
  end

  // Game FSM with sequence storage, playback timing and registered status outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= S_IDLE;
      level_r      <= LVL_W'(0);
      idx_r        <= IDX_W'(0);
      cnt_r        <= CNT_W'(0);
      led_on_r     <= 1'b0;
      round_done_r <= 1'b0;
      game_won_r   <= 1'b0;
      game_over_r  <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seq_r[i] <= 2'b00;
      end
    end else begin
      round_done_r <= 1'b0;
      case (state_r)
        S_IDLE, S_WIN, S_FAIL: begin
          if (bus.start) begin
            state_r     <= S_ADD;
            level_r     <= LVL_W'(0);
            idx_r       <= IDX_W'(0);
            game_won_r  <= 1'b0;
            game_over_r <= 1'b0;
          end
        end
        S_ADD: begin
          // level < MAX_LEN is guaranteed here, so the low bits address the array
          seq_r[level_r[IDX_W-1:0]] <= lfsr_r[1:0];
          level_r                   <= level_r + LVL_W'(1);
          idx_r                     <= IDX_W'(0);
          cnt_r                     <= CNT_W'(0);
          led_on_r                  <= 1'b1;
          state_r                   <= S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (cnt_r == CNT_W'(TICKS_ON - 1)) begin
            cnt_r    <= CNT_W'(0);
            led_on_r <= 1'b0;
            state_r  <= S_SHOW_OFF;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_SHOW_OFF: begin
          if (cnt_r == CNT_W'(TICKS_OFF - 1)) begin
            cnt_r <= CNT_W'(0);
            if (idx_inc_s < level_r) begin
              idx_r    <= idx_r + IDX_W'(1);
              led_on_r <= 1'b1;
              state_r  <= S_SHOW_ON;
            end else begin
              idx_r   <= IDX_W'(0);
              state_r <= S_WAIT_PRESS;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_WAIT_PRESS: begin
          if (bus.press) begin
            state_r <= S_CHECK;
          end else if (timeout_hit_s) begin
            game_over_r <= 1'b1;
            state_r     <= S_FAIL;
          end else begin
            state_r <= S_WAIT_PRESS;
          end
        end
        S_CHECK: begin
          // Comparator output is registered, so it is valid one cycle after the press
          if (bus.cmp_result == 2'b01) begin
            if (idx_inc_s < level_r) begin
              idx_r   <= idx_r + IDX_W'(1);
              state_r <= S_WAIT_PRESS;
            end else if (level_r < LVL_W'(MAX_LEN)) begin
              round_done_r <= 1'b1;
              state_r      <= S_ADD;
            end else begin
              game_won_r <= 1'b1;
              state_r    <= S_WIN;
            end
          end else begin
            game_over_r <= 1'b1;
            state_r     <= S_FAIL;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmp_enable = (state_r == S_WAIT_PRESS) && bus.press;
  assign bus.expected   = (state_r == S_IDLE) ? 2'b00 : seq_r[idx_r];
  assign bus.led_on     = led_on_r;
  assign bus.led_colour = led_on_r ? seq_r[idx_r] : 2'b00;
  assign bus.level      = level_r;
  assign bus.round_done = round_done_r;
  assign bus.game_won   = game_won_r;
  assign bus.game_over  = game_over_r;

endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player
// Directed bench for sequence_player with MAX_LEN=3, TICKS_ON=4, TICKS_OFF=2
// and a registered comparator model in the loop. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_sequence_player;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  sequence_player_if #(.MAX_LEN(3)) bus ();

  sequence_player #(
    .MAX_LEN      (3),
    .TICKS_ON     (4),
    .TICKS_OFF    (2),
    .SEED         (8'hA5),
    .TIMEOUT_TICKS(10)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] m_lfsr;
  logic [1:0] m_seq [3];
  logic [1:0] m_level;
  logic [1:0] colour;
  logic       en;

  // Reference LFSR, x^8+x^6+x^5+x^4+1, shifting left
  always @(posedge clk) begin
    if (!resetn) m_lfsr <= 8'hA5;
    else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // Comparator model: verdict registered one cycle after cmp_enable
  always @(posedge clk) begin
    if (!resetn)             bus.cmp_result <= 2'b00;
    else if (bus.cmp_enable) bus.cmp_result <= (colour == bus.expected) ? 2'b01 : 2'b10;
    else                     bus.cmp_result <= 2'b00;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse start for one cycle; returns at the falling edge of the ADD cycle
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Record the colour the DUT stores during the current ADD cycle
  task automatic model_add();
    m_seq[m_level] = m_lfsr[1:0];
    m_level = m_level + 2'd1;
  endtask

  // Press with colour c; reports cmp_enable seen with press high, returns in CHECK
  task automatic press_btn(input logic [1:0] c, output logic en_seen);
    colour    = c;
    bus.press = 1'b1;
    #1;
    en_seen = bus.cmp_enable;
    @(negedge clk);
    bus.press = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; bus.start = 1'b0; bus.press = 1'b0; colour = 2'b00; m_level = 2'd0;
    tick(2);
    n_checks++; if (bus.led_on !== 1'b0) begin n_errors++; $display("FAIL reset_led_on: got %0d expected 0", bus.led_on); end
    n_checks++; if (bus.led_colour !== 2'b00) begin n_errors++; $display("FAIL reset_led_colour: got %0d expected 0", bus.led_colour); end
    n_checks++; if (bus.expected !== 2'b00) begin n_errors++; $display("FAIL reset_expected: got %0d expected 0", bus.expected); end
    n_checks++; if (bus.cmp_enable !== 1'b0) begin n_errors++; $display("FAIL reset_cmp_enable: got %0d expected 0", bus.cmp_enable); end
    n_checks++; if (bus.level !== 2'd0) begin n_errors++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
    n_checks++; if (bus.round_done !== 1'b0) begin n_errors++; $display("FAIL reset_round_done: got %0d expected 0", bus.round_done); end
    n_checks++; if (bus.game_won !== 1'b0) begin n_errors++; $display("FAIL reset_game_won: got %0d expected 0", bus.game_won); end
    n_checks++; if (bus.game_over !== 1'b0) begin n_errors++; $display("FAIL reset_game_over: got %0d expected 0", bus.game_over); end
    resetn = 1'b1;
    tick(1);
  endtask

  task automatic test_first_round();
    logic       exp_on;
    logic [1:0] exp_col;
    m_level = 2'd0;
    pulse_start();
    n_checks++; if (bus.level !== 2'd0) begin n_errors++; $display("FAIL add_level: got %0d expected 0", bus.level); end
    model_add();
    tick(1);
    n_checks++; if (bus.level !== 2'd1) begin n_errors++; $display("FAIL r1_level: got %0d expected 1", bus.level); end
    for (int i = 0; i < 6; i++) begin
      exp_on  = (i < 4);
      exp_col = exp_on ? m_seq[0] : 2'b00;
      n_checks++; if (bus.led_on !== exp_on) begin n_errors++; $display("FAIL r1_led_on[%0d]: got %0d expected %0d", i, bus.led_on, exp_on); end
      n_checks++; if (bus.led_colour !== exp_col) begin n_errors++; $display("FAIL r1_led_colour[%0d]: got %0d expected %0d", i, bus.led_colour, exp_col); end
      tick(1);
    end
    n_checks++; if (bus.expected !== m_seq[0]) begin n_errors++; $display("FAIL r1_expected: got %0d expected %0d", bus.expected, m_seq[0]); end
    press_btn(m_seq[0], en);
    n_checks++; if (en !== 1'b1) begin n_errors++; $display("FAIL r1_cmp_enable: got %0d expected 1", en); end
    n_checks++; if (bus.cmp_enable !== 1'b0) begin n_errors++; $display("FAIL check_cmp_enable: got %0d expected 0", bus.cmp_enable); end
    tick(1);
    n_checks++; if (bus.round_done !== 1'b1) begin n_errors++; $display("FAIL r1_round_done: got %0d expected 1", bus.round_done); end
    model_add();
    tick(1);
    n_checks++; if (bus.round_done !== 1'b0) begin n_errors++; $display("FAIL r1_round_done_pulse: got %0d expected 0", bus.round_done); end
    n_checks++; if (bus.level !== 2'd2) begin n_errors++; $display("FAIL r2_level: got %0d expected 2", bus.level); end
    for (int i = 0; i < 12; i++) begin
      exp_on  = ((i % 6) < 4);
      exp_col = exp_on ? m_seq[i / 6] : 2'b00;
      n_checks++; if (bus.led_on !== exp_on) begin n_errors++; $display("FAIL r2_led_on[%0d]: got %0d expected %0d", i, bus.led_on, exp_on); end
      n_checks++; if (bus.led_colour !== exp_col) begin n_errors++; $display("FAIL r2_led_colour[%0d]: got %0d expected %0d", i, bus.led_colour, exp_col); end
      tick(1);
    end
    n_checks++; if (bus.expected !== m_seq[0]) begin n_errors++; $display("FAIL r2_expected0: got %0d expected %0d", bus.expected, m_seq[0]); end
  endtask

  task automatic test_wrong_press();
    press_btn(m_seq[0], en);
    n_checks++; if (en !== 1'b1) begin n_errors++; $display("FAIL r2_cmp_enable0: got %0d expected 1", en); end
    tick(1);
    n_checks++; if (bus.expected !== m_seq[1]) begin n_errors++; $display("FAIL r2_expected1: got %0d expected %0d", bus.expected, m_seq[1]); end
    n_checks++; if (bus.round_done !== 1'b0) begin n_errors++; $display("FAIL r2_mid_round_done: got %0d expected 0", bus.round_done); end
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    n_checks++; if (bus.level !== 2'd2) begin n_errors++; $display("FAIL start_in_wait_level: got %0d expected 2", bus.level); end
    n_checks++; if (bus.expected !== m_seq[1]) begin n_errors++; $display("FAIL start_in_wait_expected: got %0d expected %0d", bus.expected, m_seq[1]); end
    n_checks++; if (bus.led_on !== 1'b0) begin n_errors++; $display("FAIL start_in_wait_led: got %0d expected 0", bus.led_on); end
    press_btn(m_seq[1] ^ 2'b01, en);
    n_checks++; if (en !== 1'b1) begin n_errors++; $display("FAIL wrong_cmp_enable: got %0d expected 1", en); end
    tick(1);
    n_checks++; if (bus.game_over !== 1'b1) begin n_errors++; $display("FAIL wrong_game_over: got %0d expected 1", bus.game_over); end
    n_checks++; if (bus.level !== 2'd2) begin n_errors++; $display("FAIL wrong_level: got %0d expected 2", bus.level); end
    n_checks++; if (bus.game_won !== 1'b0) begin n_errors++; $display("FAIL wrong_game_won: got %0d expected 0", bus.game_won); end
    tick(2);
    n_checks++; if (bus.game_over !== 1'b1) begin n_errors++; $display("FAIL fail_hold: got %0d expected 1", bus.game_over); end
    m_level = 2'd0;
    pulse_start();
    n_checks++; if (bus.level !== 2'd0) begin n_errors++; $display("FAIL restart_level_clear: got %0d expected 0", bus.level); end
    n_checks++; if (bus.game_over !== 1'b0) begin n_errors++; $display("FAIL restart_game_over: got %0d expected 0", bus.game_over); end
    model_add();
    tick(1);
    n_checks++; if (bus.level !== 2'd1) begin n_errors++; $display("FAIL restart_level: got %0d expected 1", bus.level); end
  endtask

  // Starts in the first SHOW_ON cycle of a level-1 round
  task automatic test_ignored_during_show();
    logic exp_on;
    for (int i = 0; i < 6; i++) begin
      exp_on    = (i < 4);
      bus.press = 1'b1;
      #1;
      n_checks++; if (bus.cmp_enable !== 1'b0) begin n_errors++; $display("FAIL show_press_cmp_enable[%0d]: got %0d expected 0", i, bus.cmp_enable); end
      n_checks++; if (bus.led_on !== exp_on) begin n_errors++; $display("FAIL show_press_led_on[%0d]: got %0d expected %0d", i, bus.led_on, exp_on); end
      tick(1);
    end
    bus.press = 1'b0;
    #1;
    n_checks++; if (bus.led_on !== 1'b0) begin n_errors++; $display("FAIL show_press_wait_led: got %0d expected 0", bus.led_on); end
    n_checks++; if (bus.expected !== m_seq[0]) begin n_errors++; $display("FAIL show_press_expected: got %0d expected %0d", bus.expected, m_seq[0]); end
    n_checks++; if (bus.game_over !== 1'b0) begin n_errors++; $display("FAIL show_press_game_over: got %0d expected 0", bus.game_over); end
  endtask

  // Starts in WAIT_PRESS of round 1; plays rounds 1..3 correctly
  task automatic test_back_to_back();
    press_btn(m_seq[0], en);
    tick(1);
    n_checks++; if (bus.round_done !== 1'b1) begin n_errors++; $display("FAIL b2b_r1_round_done: got %0d expected 1", bus.round_done); end
    model_add();
    tick(13);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (bus.expected !== m_seq[k]) begin n_errors++; $display("FAIL b2b_r2_expected[%0d]: got %0d expected %0d", k, bus.expected, m_seq[k]); end
      press_btn(m_seq[k], en);
      n_checks++; if (en !== 1'b1) begin n_errors++; $display("FAIL b2b_r2_cmp_enable[%0d]: got %0d expected 1", k, en); end
      tick(1);
    end
    n_checks++; if (bus.round_done !== 1'b1) begin n_errors++; $display("FAIL b2b_r2_round_done: got %0d expected 1", bus.round_done); end
    model_add();
    tick(19);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (bus.expected !== m_seq[k]) begin n_errors++; $display("FAIL b2b_r3_expected[%0d]: got %0d expected %0d", k, bus.expected, m_seq[k]); end
      press_btn(m_seq[k], en);
      n_checks++; if (en !== 1'b1) begin n_errors++; $display("FAIL b2b_r3_cmp_enable[%0d]: got %0d expected 1", k, en); end
      tick(1);
    end
    n_checks++; if (bus.game_won !== 1'b1) begin n_errors++; $display("FAIL win_game_won: got %0d expected 1", bus.game_won); end
    n_checks++; if (bus.round_done !== 1'b0) begin n_errors++; $display("FAIL win_round_done: got %0d expected 0", bus.round_done); end
    n_checks++; if (bus.level !== 2'd3) begin n_errors++; $display("FAIL win_level: got %0d expected 3", bus.level); end
    n_checks++; if (bus.game_over !== 1'b0) begin n_errors++; $display("FAIL win_game_over: got %0d expected 0", bus.game_over); end
    tick(2);
    n_checks++; if (bus.game_won !== 1'b1) begin n_errors++; $display("FAIL win_hold: got %0d expected 1", bus.game_won); end
  endtask

  task automatic test_reset_mid();
    m_level = 2'd0;
    pulse_start();
    model_add();
    tick(2);
    n_checks++; if (bus.led_on !== 1'b1) begin n_errors++; $display("FAIL mid_led_on_before: got %0d expected 1", bus.led_on); end
    resetn = 1'b0;
    tick(1);
    n_checks++; if (bus.led_on !== 1'b0) begin n_errors++; $display("FAIL mid_reset_led_on: got %0d expected 0", bus.led_on); end
    n_checks++; if (bus.level !== 2'd0) begin n_errors++; $display("FAIL mid_reset_level: got %0d expected 0", bus.level); end
    n_checks++; if (bus.expected !== 2'b00) begin n_errors++; $display("FAIL mid_reset_expected: got %0d expected 0", bus.expected); end
    resetn = 1'b1;
    tick(3);
    n_checks++; if (bus.level !== 2'd0) begin n_errors++; $display("FAIL idle_after_reset_level: got %0d expected 0", bus.level); end
    n_checks++; if (bus.led_on !== 1'b0) begin n_errors++; $display("FAIL idle_after_reset_led: got %0d expected 0", bus.led_on); end
  endtask

  task automatic test_timeout();
    m_level = 2'd0;
    pulse_start();
    model_add();
    tick(7);
    n_checks++; if (bus.expected !== m_seq[0]) begin n_errors++; $display("FAIL to_expected: got %0d expected %0d", bus.expected, m_seq[0]); end
`ifdef SIMON_TIMEOUT_EN
    tick(9);
    n_checks++; if (bus.game_over !== 1'b0) begin n_errors++; $display("FAIL to_early: got %0d expected 0", bus.game_over); end
    tick(1);
    n_checks++; if (bus.game_over !== 1'b1) begin n_errors++; $display("FAIL to_game_over: got %0d expected 1", bus.game_over); end
    n_checks++; if (bus.level !== 2'd1) begin n_errors++; $display("FAIL to_level: got %0d expected 1", bus.level); end
`else
    tick(30);
    n_checks++; if (bus.game_over !== 1'b0) begin n_errors++; $display("FAIL no_to_game_over: got %0d expected 0", bus.game_over); end
    n_checks++; if (bus.expected !== m_seq[0]) begin n_errors++; $display("FAIL no_to_expected: got %0d expected %0d", bus.expected, m_seq[0]); end
    press_btn(m_seq[0], en);
    n_checks++; if (en !== 1'b1) begin n_errors++; $display("FAIL no_to_cmp_enable: got %0d expected 1", en); end
    tick(1);
    n_checks++; if (bus.round_done !== 1'b1) begin n_errors++; $display("FAIL no_to_round_done: got %0d expected 1", bus.round_done); end
`endif
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_wrong_press();
    test_ignored_during_show();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
